// File: rtl/rd73_pkg.sv
// Shared types and helpers for the rd73 vector sequencer: FSM states, input width,
// LFSR feedback taps and the golden rd73 reference (weight bit 2 of the inputs).
package rd73_pkg;

  localparam int N_IN = 7;

  // Fibonacci feedback x^7 + x^6 + 1: XOR of state bits 6 and 5
  localparam logic [N_IN-1:0] LFSR_TAPS = 7'b110_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    REPORT = 3'd4,
    FIN    = 3'd5
  } state_t;

  function automatic logic rd73_golden(input logic [N_IN-1:0] v);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      cnt = cnt + 3'(v[i]);
    end
    return cnt[2];
  endfunction

endpackage

// File: rtl/rd73_vec_gen.sv
// Vector source for the rd73 sequencer: ascending count 0..127 or LFSR walk,
// with load/advance controls and a flag marking the final vector of the run.
module rd73_vec_gen
  import rd73_pkg::*;
#(
  parameter int              CNT_W     = 16,
  parameter logic [N_IN-1:0] LFSR_SEED = 7'h5A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic             mode,
  input  logic [CNT_W-1:0] num_vec,
  output logic [N_IN-1:0]  vec,
  output logic             last
);

  logic             mode_q;
  logic [CNT_W-1:0] remain;
  logic [N_IN-1:0]  lfsr_next;

  always_comb begin
    lfsr_next = {vec[N_IN-2:0], ^(vec & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec    <= '0;
      mode_q <= 1'b0;
      remain <= '0;
    end else if (load) begin
      mode_q <= mode;
      vec    <= mode ? LFSR_SEED : '0;
      // A zero count still runs one vector
      remain <= (num_vec == '0) ? CNT_W'(1) : num_vec;
    end else if (advance) begin
      vec    <= mode_q ? lfsr_next : vec + N_IN'(1);
      remain <= remain - CNT_W'(1);
    end
  end

  always_comb begin
    last = mode_q ? (remain == CNT_W'(1)) : (vec == {N_IN{1'b1}});
  end

endmodule

// File: rtl/rd73_vector_sequencer.sv
// Stimulus/check stage for the rd73 netlist: drives vectors on x, waits SETTLE_CYC
// cycles, samples z0 against the golden model and streams per-vector results.
module rd73_vector_sequencer
  import rd73_pkg::*;
#(
  parameter int              SETTLE_CYC = 2,
  parameter logic [N_IN-1:0] LFSR_SEED  = 7'h5A,
  parameter int              CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] num_vec,
  output logic [N_IN-1:0]  x,
  input  logic             z0,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N_IN-1:0]  res_vec,
  output logic             res_z,
  output logic             res_ok,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_vld,
  output logic [N_IN-1:0]  fail_vec,
  output state_t           fsm_state
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t          state;
  state_t          state_next;
  logic [3:0]      settle_cnt;
  logic [N_IN-1:0] gen_vec;
  logic            gen_last;
  logic            gen_load;
  logic            gen_advance;
  logic            golden;
  logic            mismatch;

  rd73_vec_gen #(
    .CNT_W    (CNT_W),
    .LFSR_SEED(LFSR_SEED)
  ) u_vec_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (gen_load),
    .advance(gen_advance),
    .mode   (mode),
    .num_vec(num_vec),
    .vec    (gen_vec),
    .last   (gen_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DRIVE;
      DRIVE:   state_next = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_next = SAMPLE;
      SAMPLE:  state_next = REPORT;
      REPORT:  if (res_ready) state_next = gen_last ? FIN : DRIVE;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result stream: res_valid is high only in REPORT; res_vec/res_z/res_ok hold
  // until a rising edge sees res_valid && res_ready, which is the transfer.
  always_comb begin
    res_valid   = (state == REPORT);
    busy        = (state == DRIVE) || (state == SETTLE) ||
                  (state == SAMPLE) || (state == REPORT);
    done        = (state == FIN);
    gen_load    = (state == IDLE) && start;
    gen_advance = (state == REPORT) && res_ready && !gen_last;
    fsm_state   = state;
  end

  always_comb begin
    golden   = rd73_golden(x);
    mismatch = (z0 != golden);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x          <= '0;
      res_vec    <= '0;
      res_z      <= 1'b0;
      res_ok     <= 1'b0;
      err_cnt    <= '0;
      fail_vld   <= 1'b0;
      fail_vec   <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err_cnt  <= '0;
            fail_vld <= 1'b0;
            fail_vec <= '0;
          end
        end
        DRIVE: begin
          x          <= gen_vec;
          settle_cnt <= '0;
        end
        SETTLE: settle_cnt <= settle_cnt + 4'd1;
        SAMPLE: begin
          res_z   <= z0;
          res_vec <= x;
          res_ok  <= !mismatch;
          if (mismatch) begin
            if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
            if (!fail_vld) begin
              fail_vld <= 1'b1;
              fail_vec <= x;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rd73_vector_sequencer.sv
// Directed bench for rd73_vector_sequencer with a behavioural rd73 netlist model
// (optional single-vector fault) driving z0 back from x.
module tb_rd73_vector_sequencer;
  import rd73_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] num_vec = '0;
  logic        res_ready = 1'b1;
  logic        inject = 1'b0;

  logic [6:0]  x, res_vec, fail_vec;
  logic        z0, res_valid, res_z, res_ok, busy, done, fail_vld;
  logic [15:0] err_cnt;
  state_t      fsm_state;

  logic        s_start = 1'b0;
  logic        s_ready = 1'b1;
  logic        s_mode = 1'b0;
  logic [15:0] s_num = '0;

  logic [6:0]  s1_x, s1_res_vec, s1_fail_vec;
  logic        s1_z0, s1_res_valid, s1_res_z, s1_res_ok, s1_busy, s1_done, s1_fail_vld;
  logic [15:0] s1_err_cnt;
  state_t      s1_state;

  logic [6:0]  s15_x, s15_res_vec, s15_fail_vec;
  logic        s15_z0, s15_res_valid, s15_res_z, s15_res_ok, s15_busy, s15_done, s15_fail_vld;
  logic [15:0] s15_err_cnt;
  state_t      s15_state;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] exp_q[$];
  logic [6:0] got_vec[$];
  logic       got_z[$];
  logic       got_ok[$];
  int         run_cyc;
  int         done_cnt;

  // Reference rd73: high when four or more of the seven inputs are high
  function automatic logic ref_rd73(input logic [6:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 7; i++) c += int'(v[i]);
    return (c >= 4);
  endfunction

  always_comb z0     = ref_rd73(x) ^ (inject && (x == 7'h0F));
  always_comb s1_z0  = ref_rd73(s1_x);
  always_comb s15_z0 = ref_rd73(s15_x);

  rd73_vector_sequencer #(.SETTLE_CYC(2), .LFSR_SEED(7'h5A), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_vec(num_vec),
    .x(x), .z0(z0), .res_valid(res_valid), .res_ready(res_ready),
    .res_vec(res_vec), .res_z(res_z), .res_ok(res_ok), .busy(busy), .done(done),
    .err_cnt(err_cnt), .fail_vld(fail_vld), .fail_vec(fail_vec), .fsm_state(fsm_state)
  );

  rd73_vector_sequencer #(.SETTLE_CYC(1), .LFSR_SEED(7'h5A), .CNT_W(16)) u_s1 (
    .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .num_vec(s_num),
    .x(s1_x), .z0(s1_z0), .res_valid(s1_res_valid), .res_ready(s_ready),
    .res_vec(s1_res_vec), .res_z(s1_res_z), .res_ok(s1_res_ok), .busy(s1_busy), .done(s1_done),
    .err_cnt(s1_err_cnt), .fail_vld(s1_fail_vld), .fail_vec(s1_fail_vec), .fsm_state(s1_state)
  );

  rd73_vector_sequencer #(.SETTLE_CYC(15), .LFSR_SEED(7'h5A), .CNT_W(16)) u_s15 (
    .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .num_vec(s_num),
    .x(s15_x), .z0(s15_z0), .res_valid(s15_res_valid), .res_ready(s_ready),
    .res_vec(s15_res_vec), .res_z(s15_res_z), .res_ok(s15_res_ok), .busy(s15_busy), .done(s15_done),
    .err_cnt(s15_err_cnt), .fail_vld(s15_fail_vld), .fail_vec(s15_fail_vec), .fsm_state(s15_state)
  );

  // ---------------- driver tasks ----------------
  // Leaves the bench at the negedge of the DRIVE cycle (cycle 1 of the run)
  task automatic pulse_start(input logic m, input logic [15:0] n);
    @(negedge clk);
    mode    = m;
    num_vec = n;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Samples at each negedge starting now; records transfers and stops at done
  task automatic collect(input int budget);
    got_vec.delete();
    got_z.delete();
    got_ok.delete();
    done_cnt = 0;
    run_cyc  = -1;
    for (int c = 1; c <= budget; c++) begin
      if (res_valid && res_ready) begin
        got_vec.push_back(res_vec);
        got_z.push_back(res_z);
        got_ok.push_back(res_ok);
      end
      if (done) begin
        done_cnt = 1;
        run_cyc  = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [47:0] snap;
    int          waited;
    repeat (3) @(negedge clk);
    snap = {x, res_valid, res_vec, res_z, res_ok, busy, done, err_cnt, fail_vld, fail_vec, 3'(fsm_state)};
    n_vec++;
    if (snap !== 48'h0) begin
      n_err++;
      $display("FAIL reset_por: outputs %h, expected 0", snap);
    end
    rst = 1'b0;
    // Abort a faulty exhaustive run mid-SETTLE after 0x0F has been flagged
    inject = 1'b1;
    pulse_start(1'b0, 16'd0);
    waited = 0;
    while (!(fsm_state == SETTLE && res_vec == 7'h10) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (waited >= 300 || err_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL reset_setup: waited %0d err_cnt %0d, expected <300 and 1", waited, err_cnt);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_no_done: done %b in reset cycle %0d, expected 0", done, i);
      end
    end
    rst    = 1'b0;
    inject = 1'b0;
    @(negedge clk);
    snap = {x, res_valid, res_vec, res_z, res_ok, busy, done, err_cnt, fail_vld, fail_vec, 3'(fsm_state)};
    n_vec++;
    if (snap !== 48'h0) begin
      n_err++;
      $display("FAIL reset_midrun: outputs %h, expected 0", snap);
    end
    n_vec++;
    if (fsm_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: state %0d, expected IDLE", fsm_state);
    end
  endtask

  task automatic test_exhaustive;
    pulse_start(1'b0, 16'd0);
    collect(1000);
    n_vec++;
    if (run_cyc !== 641 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL exh_latency: cycles %0d done %0d, expected 641 and 1", run_cyc, done_cnt);
    end
    for (int i = 0; i < 128; i++) exp_q.push_back(7'(i));
    n_vec++;
    if (got_vec.size() !== 128) begin
      n_err++;
      $display("FAIL exh_count: %0d results, expected 128", got_vec.size());
    end
    for (int i = 0; i < got_vec.size() && exp_q.size() > 0; i++) begin
      logic [6:0] e;
      e = exp_q.pop_front();
      n_vec++;
      if (got_vec[i] !== e || got_z[i] !== ref_rd73(e) || got_ok[i] !== 1'b1) begin
        n_err++;
        $display("FAIL exh_result: vec %h z %b ok %b, expected vec %h z %b ok 1",
                 got_vec[i], got_z[i], got_ok[i], e, ref_rd73(e));
      end
    end
    exp_q.delete();
    n_vec++;
    if (err_cnt !== 16'd0 || fail_vld !== 1'b0) begin
      n_err++;
      $display("FAIL exh_errors: err_cnt %0d fail_vld %b, expected 0 0", err_cnt, fail_vld);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || fsm_state !== IDLE) begin
      n_err++;
      $display("FAIL exh_idle: busy %b done %b state %0d, expected 0 0 IDLE", busy, done, fsm_state);
    end
  endtask

  task automatic test_fault_inject;
    inject = 1'b1;
    pulse_start(1'b0, 16'd0);
    collect(1000);
    inject = 1'b0;
    n_vec++;
    if (got_vec.size() !== 128 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL fault_count: %0d results done %0d, expected 128 and 1", got_vec.size(), done_cnt);
    end
    for (int i = 0; i < 128; i++) exp_q.push_back(7'(i));
    for (int i = 0; i < got_vec.size() && exp_q.size() > 0; i++) begin
      logic [6:0] e;
      logic       bad;
      e   = exp_q.pop_front();
      bad = (e == 7'h0F);
      n_vec++;
      if (got_vec[i] !== e || got_z[i] !== (ref_rd73(e) ^ bad) || got_ok[i] !== !bad) begin
        n_err++;
        $display("FAIL fault_result: vec %h z %b ok %b, expected vec %h z %b ok %b",
                 got_vec[i], got_z[i], got_ok[i], e, ref_rd73(e) ^ bad, !bad);
      end
    end
    exp_q.delete();
    n_vec++;
    if (err_cnt !== 16'd1 || fail_vld !== 1'b1 || fail_vec !== 7'h0F) begin
      n_err++;
      $display("FAIL fault_summary: err_cnt %0d fail_vld %b fail_vec %h, expected 1 1 0f",
               err_cnt, fail_vld, fail_vec);
    end
    repeat (5) @(negedge clk);
    n_vec++;
    if (err_cnt !== 16'd1 || fail_vld !== 1'b1 || fail_vec !== 7'h0F) begin
      n_err++;
      $display("FAIL fault_hold: err_cnt %0d fail_vld %b fail_vec %h, expected 1 1 0f",
               err_cnt, fail_vld, fail_vec);
    end
  endtask

  task automatic test_backpressure;
    logic [6:0] rv, rx;
    logic       rz, rok;
    int         waited;
    res_ready = 1'b0;
    pulse_start(1'b1, 16'd3);
    waited = 0;
    while (!res_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    rv = res_vec; rx = x; rz = res_z; rok = res_ok;
    n_vec++;
    if (!res_valid || rv !== 7'h5A || rz !== 1'b1 || rok !== 1'b1) begin
      n_err++;
      $display("FAIL bp_first: valid %b vec %h z %b ok %b, expected 1 5a 1 1", res_valid, rv, rz, rok);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (res_valid !== 1'b1 || res_vec !== rv || res_z !== rz || res_ok !== rok ||
          x !== rx || fsm_state !== REPORT) begin
        n_err++;
        $display("FAIL bp_stall: valid %b vec %h z %b x %h state %0d, expected 1 %h %b %h REPORT",
                 res_valid, res_vec, res_z, x, fsm_state, rv, rz, rx);
      end
    end
    res_ready = 1'b1;
    collect(200);
    exp_q = '{7'h5A, 7'h35, 7'h6B};
    n_vec++;
    if (got_vec.size() !== 3 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL bp_count: %0d results done %0d, expected 3 and 1", got_vec.size(), done_cnt);
    end
    for (int i = 0; i < got_vec.size() && exp_q.size() > 0; i++) begin
      logic [6:0] e;
      e = exp_q.pop_front();
      n_vec++;
      if (got_vec[i] !== e || got_ok[i] !== 1'b1) begin
        n_err++;
        $display("FAIL bp_seq: vec %h ok %b, expected %h 1", got_vec[i], got_ok[i], e);
      end
    end
    exp_q.delete();
    n_vec++;
    if (err_cnt !== 16'd0 || fail_vld !== 1'b0 || fail_vec !== 7'h00) begin
      n_err++;
      $display("FAIL bp_cleared: err_cnt %0d fail_vld %b fail_vec %h, expected 0 0 00",
               err_cnt, fail_vld, fail_vec);
    end
  endtask

  task automatic test_random_zero;
    pulse_start(1'b1, 16'd0);
    collect(100);
    n_vec++;
    if (got_vec.size() !== 1 || run_cyc !== 6 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL rnd_zero: %0d results cycles %0d done %0d, expected 1 6 1",
               got_vec.size(), run_cyc, done_cnt);
    end
    n_vec++;
    if (got_vec.size() > 0 && got_vec[0] !== 7'h5A) begin
      n_err++;
      $display("FAIL rnd_zero_vec: vec %h, expected 5a", got_vec[0]);
    end
  endtask

  task automatic test_back_to_back;
    pulse_start(1'b1, 16'd3);
    repeat (2) @(negedge clk);
    start   = 1'b1;
    mode    = 1'b0;
    num_vec = 16'd9;
    @(negedge clk);
    start = 1'b0;
    collect(200);
    exp_q = '{7'h5A, 7'h35, 7'h6B};
    n_vec++;
    if (got_vec.size() !== 3 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL busy_start_count: %0d results done %0d, expected 3 1", got_vec.size(), done_cnt);
    end
    for (int i = 0; i < got_vec.size() && exp_q.size() > 0; i++) begin
      logic [6:0] e;
      e = exp_q.pop_front();
      n_vec++;
      if (got_vec[i] !== e) begin
        n_err++;
        $display("FAIL busy_start_seq: vec %h, expected %h", got_vec[i], e);
      end
    end
    exp_q.delete();
    // Restart right after the previous run returns to IDLE
    pulse_start(1'b1, 16'd2);
    collect(100);
    n_vec++;
    if (got_vec.size() !== 2 || run_cyc !== 11 ||
        (got_vec.size() == 2 && (got_vec[0] !== 7'h5A || got_vec[1] !== 7'h35))) begin
      n_err++;
      $display("FAIL b2b_run: %0d results cycles %0d, expected 2 results 5a 35 in 11 cycles",
               got_vec.size(), run_cyc);
    end
  endtask

  task automatic test_settle_extremes;
    int e1, e15, cyc1, cyc15;
    e1 = 0; e15 = 0; cyc1 = 0; cyc15 = 0;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      if (s1_res_valid) begin
        n_vec++;
        if (s1_res_vec !== 7'(e1) || s1_res_ok !== 1'b1 || s1_res_z !== ref_rd73(7'(e1))) begin
          n_err++;
          $display("FAIL s1_result: vec %h ok %b, expected %h 1", s1_res_vec, s1_res_ok, 7'(e1));
        end
        e1++;
      end
      if (s15_res_valid) begin
        n_vec++;
        if (s15_res_vec !== 7'(e15) || s15_res_ok !== 1'b1 || s15_res_z !== ref_rd73(7'(e15))) begin
          n_err++;
          $display("FAIL s15_result: vec %h ok %b, expected %h 1", s15_res_vec, s15_res_ok, 7'(e15));
        end
        e15++;
      end
      if (s1_done && cyc1 == 0) cyc1 = c;
      if (s15_done && cyc15 == 0) cyc15 = c;
      if (cyc1 != 0 && cyc15 != 0) break;
      @(negedge clk);
    end
    n_vec++;
    if (e1 !== 128 || cyc1 !== 513 || s1_err_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL s1_run: %0d results done at %0d err %0d, expected 128 513 0", e1, cyc1, s1_err_cnt);
    end
    n_vec++;
    if (e15 !== 128 || cyc15 !== 2305 || s15_err_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL s15_run: %0d results done at %0d err %0d, expected 128 2305 0", e15, cyc15, s15_err_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_exhaustive();
    test_fault_inject();
    test_backpressure();
    test_random_zero();
    test_back_to_back();
    test_settle_extremes();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
